// File: rtl/com_send_arb.sv
// com_send_arb: round-robin arbiter sharing one COM send path among NUM_REQ fs/fd requesters.
// Optional send watchdog is built when COM_SEND_ARB_TIMEOUT_EN is defined.
module com_send_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   fs_req,
  output logic [NUM_REQ-1:0]   fd_req,
  input  logic [4*NUM_REQ-1:0] req_btype,
  output logic                 fs_com_send,
  input  logic                 fd_com_send,
  output logic [3:0]           com_send_btype,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_DONE = 2'd2,
    ARB_REL  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nx;
  logic [ID_W-1:0]    grant_nx;
  logic [ID_W-1:0]    pick;
  logic [3:0]         btype_nx;
  logic               fs_nx;
  logic               busy_nx;
  logic               found;
  logic               hit;
  logic               expire;
  logic [NUM_REQ-1:0] fd_nx;
  logic [ID_W:0]      scan;

  // First pending request at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    scan  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan  = {1'b0, ptr} + (ID_W+1)'(k);
      scan  = (scan >= (ID_W+1)'(NUM_REQ)) ? scan - (ID_W+1)'(NUM_REQ) : scan;
      hit   = fs_req[scan[ID_W-1:0]];
      pick  = (!found && hit) ? scan[ID_W-1:0] : pick;
      found = found | hit;
    end
  end

`ifdef COM_SEND_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt;

  // Watchdog: counts sampled cycles spent in ARB_SEND, cleared on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ARB_IDLE && state_nx == ARB_SEND) begin
      cnt <= '0;
    end else if (state == ARB_SEND) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = (state == ARB_SEND) && !fd_com_send && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end else begin
      timeout_err <= timeout_err;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = grant_id;
    btype_nx = com_send_btype;
    fs_nx    = fs_com_send;
    fd_nx    = fd_req;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          state_nx = ARB_SEND;
          grant_nx = pick;
          btype_nx = req_btype[{pick, 2'b00} +: 4];
          fs_nx    = 1'b1;
        end else begin
          state_nx = ARB_IDLE;
        end
      end
      ARB_SEND: begin
        if (fd_com_send || expire) begin
          state_nx = ARB_DONE;
          fs_nx    = 1'b0;
          fd_nx    = NUM_REQ'(1) << grant_id;
        end else begin
          state_nx = ARB_SEND;
        end
      end
      ARB_DONE: begin
        if (!fs_req[grant_id]) begin
          state_nx = ARB_REL;
          fd_nx    = '0;
          ptr_nx   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end else begin
          state_nx = ARB_DONE;
        end
      end
      ARB_REL: begin
        // A sender done still high from the last transfer must fall first.
        if (!fd_com_send) begin
          state_nx = ARB_IDLE;
        end else begin
          state_nx = ARB_REL;
        end
      end
      default: begin
        state_nx = ARB_IDLE;
        fs_nx    = 1'b0;
        fd_nx    = '0;
      end
    endcase
    busy_nx = (state_nx != ARB_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ARB_IDLE;
      ptr            <= '0;
      grant_id       <= '0;
      com_send_btype <= 4'h0;
      fs_com_send    <= 1'b0;
      fd_req         <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      ptr            <= ptr_nx;
      grant_id       <= grant_nx;
      com_send_btype <= btype_nx;
      fs_com_send    <= fs_nx;
      fd_req         <= fd_nx;
      busy           <= busy_nx;
    end
  end

endmodule

// File: tb/tb_com_send_arb.sv
// Bench for com_send_arb: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the arbitration rules.
module tb_com_send_arb;
  localparam int N = 4;
`ifdef COM_SEND_ARB_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] fs_req;
  logic [N-1:0] fd_req;
  logic [4*N-1:0] req_btype;
  logic         fs_com_send;
  logic         fd_com_send;
  logic [3:0]   com_send_btype;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  com_send_arb #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .fs_req(fs_req), .fd_req(fd_req), .req_btype(req_btype),
    .fs_com_send(fs_com_send), .fd_com_send(fd_com_send), .com_send_btype(com_send_btype),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the current transaction is "offered" (waiting for sender), "acked"
  // (waiting for requester release) or "draining" (waiting for sender done to fall).
  bit         started = 1'b0;
  bit         in_txn, offered, acked, draining;
  int         cur, rr_next, waited;
  logic [3:0] cur_bt;
  logic       sticky_to;
  int         grants[$];
  logic       prev_fs = 1'b0;

  always @(posedge clk) begin : model
    int w;
    started <= 1'b1;
    if (!rst) begin
      in_txn <= 1'b0; offered <= 1'b0; acked <= 1'b0; draining <= 1'b0;
      cur <= 0; rr_next <= 0; cur_bt <= 4'h0; sticky_to <= 1'b0; waited <= 0;
    end else if (!in_txn) begin
      w = -1;
      for (int k = N - 1; k >= 0; k--)
        if (fs_req[(rr_next + k) % N]) w = (rr_next + k) % N;
      if (w >= 0) begin
        in_txn <= 1'b1; offered <= 1'b1; cur <= w; cur_bt <= req_btype[4*w +: 4]; waited <= 0;
      end
    end else if (offered) begin
      if (fd_com_send || (TO_EN && waited + 1 == TO)) begin
        offered <= 1'b0; acked <= 1'b1;
        if (!fd_com_send) sticky_to <= 1'b1;
      end else begin
        waited <= waited + 1;
      end
    end else if (acked) begin
      if (!fs_req[cur]) begin
        acked <= 1'b0; draining <= 1'b1; rr_next <= (cur + 1) % N;
      end
    end else if (draining) begin
      if (!fd_com_send) begin
        draining <= 1'b0; in_txn <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the reference.
  always @(negedge clk) begin
    logic [N-1:0] e_fd;
    if (started) begin
      e_fd = acked ? (N'(1) << cur) : '0;
      checks++;
      if (fs_com_send !== offered || fd_req !== e_fd || com_send_btype !== cur_bt ||
          grant_id !== 2'(cur) || busy !== in_txn || timeout_err !== sticky_to) begin
        errors++;
        $display("FAIL model t=%0t got fs=%b fd=%b bt=%h gid=%0d busy=%b to=%b want fs=%b fd=%b bt=%h gid=%0d busy=%b to=%b",
                 $time, fs_com_send, fd_req, com_send_btype, grant_id, busy, timeout_err,
                 offered, e_fd, cur_bt, cur, in_txn, sticky_to);
      end
      if (fs_com_send && !prev_fs) grants.push_back(int'(grant_id));
      prev_fs <= fs_com_send;
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Advance to the drive point: 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; fs_req = '0; fd_com_send = 1'b0;
    tick();
    rst = 1'b1;
    grants.delete();
  endtask

  // Sender answers one cycle after fs_com_send; requesters release on ack.
  task automatic run_auto(input int target, input bit reraise, input int budget);
    int n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (grants.size() >= target) break;
      fd_com_send = fs_com_send;
      for (int i = 0; i < N; i++) begin
        if (fd_req[i]) fs_req[i] = 1'b0;
        else if (reraise && !fs_req[i]) fs_req[i] = 1'b1;
      end
    end
    chk("grant_budget", int'(grants.size() >= target), 1);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (n < budget) begin
      tick();
      n++;
      if (!busy) break;
      fd_com_send = fs_com_send;
      for (int i = 0; i < N; i++) if (fd_req[i]) fs_req[i] = 1'b0;
    end
    chk("idle_budget", int'(busy), 0);
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  logic [3:0] bt_tab[4] = '{4'h1, 4'h5, 4'h9, 4'hD};

  initial begin
    rst = 1'b0; fs_req = '0; fd_com_send = 1'b0; req_btype = '0;
    repeat (3) tick();
    chk("reset_outs", int'({fs_com_send, fd_req, com_send_btype, grant_id, busy, timeout_err}), 0);

    // Single request from requester 1 with bag type 5.
    rst = 1'b1; fs_req = 4'b0010; req_btype = 16'h0050;
    tick();
    chk("single_fs", int'(fs_com_send), 1);
    chk("single_bt", int'(com_send_btype), 5);
    chk("single_gid", int'(grant_id), 1);
    chk("single_busy", int'(busy), 1);
    fd_com_send = 1'b1;
    tick();
    chk("single_fd", int'(fd_req), 4'b0010);
    chk("single_fs_drop", int'(fs_com_send), 0);
    fd_com_send = 1'b0; req_btype = 16'hFFFF;
    tick();
    tick();
    chk("single_fd_hold", int'(fd_req), 4'b0010);
    chk("single_bt_latched", int'(com_send_btype), 5);
    fs_req = 4'b0000;
    tick();
    chk("single_fd_clr", int'(fd_req), 0);
    chk("single_busy_rel", int'(busy), 1);
    tick();
    chk("single_busy_fall", int'(busy), 0);

    // Round robin with all four requesting continuously.
    do_reset();
    fs_req = 4'b1111;
    run_auto(6, 1'b1, 200);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), (grants.size() > i) ? grants[i] : 99, rr_exp[i]);

    // Pointer wrap after serving requester 3.
    do_reset();
    fs_req = 4'b1000;
    run_auto(1, 1'b0, 50);
    run_idle(50);
    fs_req = 4'b1001;
    run_auto(2, 1'b0, 50);
    chk("wrap_grant", (grants.size() > 1) ? grants[1] : 99, 0);

    // Early drop of the granted request during ARB_SEND.
    do_reset();
    fs_req = 4'b0100;
    tick();
    chk("early_gid", int'(grant_id), 2);
    fs_req = 4'b0000;
    tick();
    fd_com_send = 1'b1;
    tick();
    chk("early_fd_on", int'(fd_req), 4'b0100);
    fd_com_send = 1'b0;
    tick();
    chk("early_fd_off", int'(fd_req), 0);

    // Reset in the middle of ARB_SEND.
    tick();
    fs_req = 4'b0001;
    tick();
    chk("midrst_fs_pre", int'(fs_com_send), 1);
    rst = 1'b0;
    tick();
    chk("midrst_fs", int'(fs_com_send), 0);
    chk("midrst_fd", int'(fd_req), 0);
    rst = 1'b1; fs_req = 4'b0000;

    // Stale sender done must not start or finish the next transaction.
    tick();
    fs_req = 4'b0001;
    tick();
    chk("stale_fs_on", int'(fs_com_send), 1);
    fd_com_send = 1'b1;
    tick();
    chk("stale_ack", int'(fd_req), 4'b0001);
    fs_req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stale_hold%0d", i), int'(fs_com_send), 0);
    end
    fd_com_send = 1'b0;
    tick();
    tick();
    chk("stale_next_fs", int'(fs_com_send), 1);
    chk("stale_next_gid", int'(grant_id), 1);

`ifdef COM_SEND_ARB_TIMEOUT_EN
    // Sender never answers: watchdog aborts after TO cycles.
    begin
      int hi = 0;
      do_reset();
      fs_req = 4'b0001;
      tick();
      while (fs_com_send && hi < 100) begin
        hi++;
        tick();
      end
      chk("to_len", hi, TO);
      chk("to_err", int'(timeout_err), 1);
      chk("to_fd", int'(fd_req), 4'b0001);
      fs_req = 4'b0000;
      tick();
    end
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (fs_com_send && !fd_com_send) begin
        if ($urandom_range(2, 0) == 0) fd_com_send = 1'b1;
      end else if (fd_com_send && !fs_com_send) begin
        if ($urandom_range(1, 0) == 0) fd_com_send = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7, 0) == 0) req_btype[4*i +: 4] = bt_tab[$urandom_range(3, 0)];
        if (fs_req[i]) begin
          if (fd_req[i] && $urandom_range(1, 0) == 0) fs_req[i] = 1'b0;
          else if (offered && cur == i && $urandom_range(19, 0) == 0) fs_req[i] = 1'b0;
        end else if (!fd_req[i] && $urandom_range(3, 0) == 0) begin
          fs_req[i] = 1'b1;
        end
      end
      rst = ($urandom_range(499, 0) == 0) ? 1'b0 : 1'b1;
    end
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
